// File: rtl/arena_pkg.sv
// Shared arena geometry, cell encoding and scan-state type for the arena
// initialiser / reader / cursor family.
package arena_pkg;

    localparam int ARENA_ROWS  = 10;
    localparam int ARENA_COLS  = 10;
    localparam int ARENA_CELLS = ARENA_ROWS * ARENA_COLS;
    localparam int ARENA_IDX_W = $clog2(ARENA_CELLS);
    localparam int ARENA_RC_W  = 4;

    localparam logic CELL_EMPTY = 1'b0;
    localparam logic CELL_SOLID = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/arena_cursor.sv
// Row-major arena cursor: row/col pair plus a flat index counter kept in step,
// so callers get row*COLS+col without a multiplier. last_o flags the final cell.
module arena_cursor
    import arena_pkg::*;
#(
    parameter int ROWS  = ARENA_ROWS,
    parameter int COLS  = ARENA_COLS,
    parameter int IDX_W = ARENA_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  adv_i,
    output logic [ARENA_RC_W-1:0] row_o,
    output logic [ARENA_RC_W-1:0] col_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  last_o
);

    logic [ARENA_RC_W-1:0] row_q, row_d;
    logic [ARENA_RC_W-1:0] col_q, col_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  col_wrap;

    assign col_wrap = (col_q == ARENA_RC_W'(COLS - 1));

    // Clear has priority so a restart never sees a stale advance.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        idx_d = idx_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
            idx_d = '0;
        end else if (adv_i) begin
            idx_d = idx_q + IDX_W'(1);
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + ARENA_RC_W'(1);
            end else begin
                col_d = col_q + ARENA_RC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            idx_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            idx_q <= idx_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign idx_o  = idx_q;
    assign last_o = (row_q == ARENA_RC_W'(ROWS - 1)) && col_wrap;

endmodule

// File: rtl/arena_cell_reader.sv
// Streams a snapshot of the flat arena occupancy map one cell per beat over
// valid/ready, optionally skipping empty cells, and reports the occupied count.
module arena_cell_reader
    import arena_pkg::*;
#(
    parameter int ROWS  = ARENA_ROWS,
    parameter int COLS  = ARENA_COLS,
    parameter int CELLS = ROWS * COLS,
    parameter int IDX_W = $clog2(CELLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CELLS-1:0] arena,
    input  logic             start,
    input  logic             skip_empty,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [3:0]       out_row,
    output logic [3:0]       out_col,
    output logic             out_occ,
    output logic             done,
    output logic [IDX_W-1:0] occ_count
);

    scan_state_e           state_q, state_d;
    logic [CELLS-1:0]      snap_q, snap_d;
    logic                  mode_q, mode_d;
    logic [IDX_W-1:0]      occ_q, occ_d;

    logic                  cur_clr, cur_adv, cur_last;
    logic [IDX_W-1:0]      cur_idx;
    logic [ARENA_RC_W-1:0] cur_row, cur_col;
    logic                  cur_occ;
    logic                  hs, step;

    arena_cursor #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .IDX_W (IDX_W)
    ) u_cursor (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cur_clr),
        .adv_i  (cur_adv),
        .row_o  (cur_row),
        .col_o  (cur_col),
        .idx_o  (cur_idx),
        .last_o (cur_last)
    );

    assign cur_occ = snap_q[cur_idx];

    // A cell is retired either by its handshake or, when it is not
    // presented, by simply passing over it in one cycle.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        mode_d    = mode_q;
        occ_d     = occ_q;
        cur_clr   = 1'b0;
        cur_adv   = 1'b0;
        out_valid = 1'b0;
        hs        = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = arena;
                    mode_d  = skip_empty;
                    occ_d   = '0;
                    cur_clr = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                out_valid = !mode_q || (cur_occ != CELL_EMPTY);
                hs        = out_valid && out_ready;
                step      = hs || !out_valid;
                if (hs && (cur_occ == CELL_SOLID)) begin
                    occ_d = occ_q + IDX_W'(1);
                end
                if (step) begin
                    if (cur_last) begin
                        state_d = DONE;
                    end else begin
                        cur_adv = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            mode_q  <= 1'b0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            mode_q  <= mode_d;
            occ_q   <= occ_d;
        end
    end

    assign busy      = (state_q == SCAN);
    assign done      = (state_q == DONE);
    assign out_idx   = cur_idx;
    assign out_row   = cur_row;
    assign out_col   = cur_col;
    assign out_occ   = cur_occ;
    assign occ_count = occ_q;

endmodule

// File: doc/arena_cell_reader.md
Name: arena_cell_reader

Overview:
- Read-side companion to the arena initialiser: takes the flat 100-bit arena occupancy map (cell index = row*COLS + col; 1 = wall/block) and streams it out one cell per beat over a valid/ready interface.
- Feeds tile renderers, collision tables and debug dumps that need arena contents serially rather than as a wide bus.
- Snapshots the map on start, so upstream writes during a scan do not tear the stream.

Parameters:
- ROWS, 10, arena rows.
- COLS, 10, arena columns.
- CELLS, ROWS*COLS, map width in bits (derived; do not override).
- IDX_W, $clog2(CELLS), width of cell index and count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arena  in  CELLS  occupancy map, bit i = cell i.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- skip_empty  in  1  mode, sampled with start; 1 = emit occupied cells only.
- busy  out  1  high from the cycle after start acceptance until done.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- out_idx  out  IDX_W  cell index of the beat.
- out_row  out  4  row of the beat (0..ROWS-1).
- out_col  out  4  column of the beat (0..COLS-1).
- out_occ  out  1  occupancy bit of the beat.
- done  out  1  one-cycle pulse when the scan completes.
- occ_count  out  IDX_W  number of occupied cells seen in the last scan; valid from done, held until the next start.

Behaviour:
- Reset (async, rst_n=0) clears all state, whatever the current state:
  - state=IDLE.
  - busy, out_valid, done = 0.
  - out_idx, out_row, out_col, out_occ, occ_count = 0.
  - snapshot register = 0.
  - The internal cursor is cleared too; an in-flight scan is abandoned with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 at edge T:
  - snapshot <= arena; mode <= skip_empty.
  - cursor <= 0 (row 0, col 0); occ_count <= 0.
  - state <= SCAN; busy=1 from T+1.
  - start in SCAN or DONE is ignored.
- SCAN, full mode:
  - The cell at the cursor is presented with out_valid=1, first beat at T+1.
  - out_* stay stable while out_valid && !out_ready.
  - On a handshake (out_valid && out_ready), the cursor advances and the next cell is presented the following cycle, so out_valid stays high. Throughput is 1 beat/cycle.
- SCAN, skip mode:
  - An empty cell at the cursor is not presented (out_valid=0); the cursor advances 1 cell/cycle.
  - An occupied cell is presented exactly as in full mode.
- occ_count increments on each handshake of a beat with out_occ=1.
- Cursor advance: col increments; at col=COLS-1 it wraps to 0 and row increments. out_idx = row*COLS+col, kept as a separate incrementing counter (no multiplier).
- Last cell (idx CELLS-1):
  - If it is presented, its handshake moves state to DONE.
  - If it is skipped, its skip cycle moves state to DONE.
- DONE: done=1, busy=0, out_valid=0 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- All-empty map in skip mode: no beats; done occurs CELLS+1 cycles after the start edge (T+1 through T+100 are the 100 skip cycles, DONE at T+101); occ_count=0.
- out_ready may be high without out_valid; this has no effect.
- Changes on arena during SCAN do not affect the stream.

Decomposition:
- Shared package arena_pkg holds:
  - ARENA_ROWS=10, ARENA_COLS=10, ARENA_CELLS=100, ARENA_IDX_W=7.
  - The cell encoding constants CELL_EMPTY=0, CELL_SOLID=1.
  - The scan-state enum {IDLE, SCAN, DONE}.
- One sub-module is natural: arena_cursor, a row/col/idx counter with wrap and a last flag. It is reusable by a future arena writer.

Test Plan:
- Default initialised map (border plus 14 blocks), skip_empty=0, out_ready=1 constantly -> 100 consecutive beats at T+1..T+100; beat 13 has out_occ=1, row 1, col 3; beat 11 has out_occ=0; done at T+101; occ_count=50.
- Same map, skip_empty=1, out_ready=1 -> 50 beats; out_idx sequence begins 0..9, 10, 13, 17, 19, 20; last beat idx 99; occ_count=50.
- Same map, full mode, out_ready toggling 1,0,1,0 -> out_* held stable on every ready=0 cycle; exactly 100 handshakes; idx strictly 0..99 with no duplicates or drops.
- All-zero map, skip_empty=1 -> no out_valid; done exactly 101 cycles after the start edge; occ_count=0.
- Start in full mode; at beat 40, flip every arena input bit and pulse start again -> stream still reflects the snapshot (idx 46 occ=1); the second start is ignored; a single done.
- Drive rst_n low at beat 57 -> all outputs 0 immediately (asynchronous), no done; after release, a new start produces a fresh scan from idx 0.
